// File: rtl/fmv_pixel_scheduler.sv
// fmv_pixel_scheduler: paces decoded pixels from the FIFO out to the display
// path. Each newpixel strobe from the sample rate converter emits one pixel.
// When the FIFO is empty a black pixel is substituted and counted. vsync and
// hsync frame the lines, and they also restart the converter's phase accumulator.
//
// Handshake: fifo_ready is a combinational pop strobe. The FIFO drops its head
// on any cycle where fifo_ready=1, and fifo_ready is only ever 1 while
// fifo_valid=1. fifo_data is consumed in that same cycle. pix_valid is a
// one-cycle qualifier on pix_data. There is no back-pressure downstream.
module fmv_pixel_scheduler #(
  parameter int kDataWidth  = 24,
  parameter int kCountWidth = 10
) (
  input  logic                   clk30,
  input  logic                   reset_n,
  input  logic                   vcd_mode_req,
  input  logic                   vsync,
  input  logic                   hsync,
  input  logic [kCountWidth-1:0] line_width,
  input  logic                   newpixel,
  input  logic                   fifo_valid,
  input  logic [kDataWidth-1:0]  fifo_data,
  output logic                   fifo_ready,
  output logic                   vcd_mode,
  output logic                   src_reset,
  output logic                   pix_valid,
  output logic [kDataWidth-1:0]  pix_data,
  output logic [7:0]             underrun_count,
  output logic [1:0]             state_dbg
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_LINE = 2'd1;
  localparam logic [1:0] ACTIVE    = 2'd2;

  localparam logic [kCountWidth-1:0] kCountOne = kCountWidth'(1);
  localparam logic [7:0]             kUrMax    = 8'hFF;

  logic [1:0]             state_q, state_d;
  logic                   vcd_mode_q, vcd_mode_d;
  logic                   src_reset_q, src_reset_d;
  logic                   pix_valid_q, pix_valid_d;
  logic [kDataWidth-1:0]  pix_data_q, pix_data_d;
  logic [7:0]             underrun_q, underrun_d;
  logic [kCountWidth-1:0] count_q, count_d;
  logic [kCountWidth-1:0] width_q, width_d;

  logic line_start;
  logic emit;

  // hsync starts a new line from WAIT_LINE and also truncates a line in
  // ACTIVE. vsync overrides both.
  assign line_start = hsync && !vsync && ((state_q == WAIT_LINE) || (state_q == ACTIVE));
  // A pixel goes out only on a clean newpixel in ACTIVE. Framing pulses take
  // priority over it.
  assign emit       = (state_q == ACTIVE) && newpixel && !vsync && !hsync;

  assign fifo_ready     = emit && fifo_valid;
  assign vcd_mode       = vcd_mode_q;
  assign src_reset      = src_reset_q;
  assign pix_valid      = pix_valid_q;
  assign pix_data       = pix_data_q;
  assign underrun_count = underrun_q;
  assign state_dbg      = state_q;

  // Next-state logic. vsync wins, then a line (re)start, then pixel emission.
  always_comb begin
    state_d     = state_q;
    vcd_mode_d  = vcd_mode_q;
    src_reset_d = 1'b0;
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    underrun_d  = underrun_q;
    count_d     = count_q;
    width_d     = width_q;
    if (vsync) begin
      state_d     = WAIT_LINE;
      vcd_mode_d  = vcd_mode_req;
      src_reset_d = 1'b1;
    end else if (line_start) begin
      width_d     = line_width;
      count_d     = '0;
      src_reset_d = 1'b1;
      // A zero-width line has nothing to emit, so the block keeps waiting.
      state_d     = (line_width == '0) ? WAIT_LINE : ACTIVE;
    end else if (emit) begin
      pix_valid_d = 1'b1;
      if (fifo_valid) begin
        pix_data_d = fifo_data;
      end else begin
        pix_data_d = '0;
        if (underrun_q != kUrMax) underrun_d = underrun_q + 8'd1;
      end
      count_d = count_q + kCountOne;
      if (count_q == width_q - kCountOne) state_d = WAIT_LINE;
    end
  end

  // State and output registers. src_reset is held high throughout reset.
  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      vcd_mode_q  <= 1'b0;
      src_reset_q <= 1'b1;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      underrun_q  <= '0;
      count_q     <= '0;
      width_q     <= '0;
    end else begin
      state_q     <= state_d;
      vcd_mode_q  <= vcd_mode_d;
      src_reset_q <= src_reset_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      underrun_q  <= underrun_d;
      count_q     <= count_d;
      width_q     <= width_d;
    end
  end

endmodule

// File: tb/tb_fmv_pixel_scheduler.sv
// Bench for fmv_pixel_scheduler. Directed scenarios and a random run are
// checked every cycle against a line-level reference model. A queue holds
// the expected pixels.
module tb_fmv_pixel_scheduler;

  localparam int DW = 24;
  localparam int CW = 10;

  // Model line phases.
  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_LINE = 2;

  logic          clk30;
  logic          reset_n;
  logic          vcd_mode_req;
  logic          vsync;
  logic          hsync;
  logic [CW-1:0] line_width;
  logic          newpixel;
  logic          fifo_valid;
  logic [DW-1:0] fifo_data;
  logic          fifo_ready;
  logic          vcd_mode;
  logic          src_reset;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic [7:0]    underrun_count;
  logic [1:0]    state_dbg;

  int checks;
  int errors;
  int pop_cnt;
  int pv_cnt;

  // Reference model: the phase of the current line, how many pixels remain in
  // it, and the outputs expected after the next edge.
  int          m_phase;
  int          m_left;
  int          m_under;
  logic        m_vcd;
  logic        m_src;
  logic        m_pv;
  logic [DW-1:0] m_pd;
  logic [DW-1:0] exp_q[$];

  fmv_pixel_scheduler #(.kDataWidth(DW), .kCountWidth(CW)) dut (
    .clk30          (clk30),
    .reset_n        (reset_n),
    .vcd_mode_req   (vcd_mode_req),
    .vsync          (vsync),
    .hsync          (hsync),
    .line_width     (line_width),
    .newpixel       (newpixel),
    .fifo_valid     (fifo_valid),
    .fifo_data      (fifo_data),
    .fifo_ready     (fifo_ready),
    .vcd_mode       (vcd_mode),
    .src_reset      (src_reset),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .underrun_count (underrun_count),
    .state_dbg      (state_dbg)
  );

  // Clock: 30 MHz nominal, modelled as a 10 ns period.
  initial clk30 = 1'b0;
  always #5 clk30 = ~clk30;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_left  = 0;
    m_under = 0;
    m_vcd   = 1'b0;
    m_src   = 1'b1;
    m_pv    = 1'b0;
    m_pd    = '0;
    exp_q.delete();
  endtask

  // Applies one clock edge of the rules to the model, using the inputs held by the bench.
  task automatic model_update();
    m_src = 1'b0;
    m_pv  = 1'b0;
    if (vsync) begin
      m_phase = P_WAIT;
      m_vcd   = vcd_mode_req;
      m_src   = 1'b1;
    end else if (hsync && m_phase != P_IDLE) begin
      m_left  = int'(line_width);
      m_src   = 1'b1;
      m_phase = (m_left == 0) ? P_WAIT : P_LINE;
    end else if (newpixel && m_phase == P_LINE) begin
      m_pv = 1'b1;
      m_pd = fifo_valid ? fifo_data : '0;
      if (!fifo_valid) m_under = (m_under + 1 > 255) ? 255 : m_under + 1;
      exp_q.push_back(m_pd);
      m_left--;
      if (m_left == 0) m_phase = P_WAIT;
    end
  endtask

  // One clock cycle. Checks the combinational pop before the edge and the
  // registered outputs after it.
  task automatic step();
    logic exp_ready;
    logic [DW-1:0] sb;
    fifo_data = DW'($urandom());
    #1;
    exp_ready = (m_phase == P_LINE) && newpixel && fifo_valid && !vsync && !hsync;
    check("fifo_ready", fifo_ready, exp_ready);
    if (fifo_ready) pop_cnt++;
    @(posedge clk30);
    model_update();
    #1;
    check("pix_valid", pix_valid, m_pv);
    if (pix_valid) begin
      pv_cnt++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pixel", 32'd1, 32'd0);
      end else begin
        sb = exp_q.pop_front();
        check("sb_pixel", pix_data, sb);
      end
    end
    check("pix_data_hold", pix_data, m_pd);
    check("vcd_mode", vcd_mode, m_vcd);
    check("src_reset", src_reset, m_src);
    check("underrun_count", underrun_count, m_under);
  endtask

  task automatic cyc(input logic v, input logic h, input logic np, input logic fv);
    vsync = v;
    hsync = h;
    newpixel = np;
    fifo_valid = fv;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    vcd_mode_req = 1'b0;
    vsync = 1'b0;
    hsync = 1'b0;
    line_width = '0;
    newpixel = 1'b1;
    fifo_valid = 1'b1;
    fifo_data = '0;
    model_reset();

    // Reset values, with pop-qualifying inputs held high.
    repeat (2) @(posedge clk30);
    #1;
    check("rst_fifo_ready", fifo_ready, 1'b0);
    check("rst_vcd_mode", vcd_mode, 1'b0);
    check("rst_src_reset", src_reset, 1'b1);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_pix_data", pix_data, 0);
    check("rst_underrun", underrun_count, 0);
    reset_n = 1'b1;

    // src_reset drops on the first edge. IDLE ignores hsync and newpixel.
    cyc(0, 0, 0, 0);
    check("src_reset_drop", src_reset, 1'b0);
    line_width = 10'd3;
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 1);
    check("idle_no_pixel", pix_valid, 1'b0);

    // vsync with White Book requested: the mode latches and src_reset pulses for one cycle.
    vcd_mode_req = 1'b1;
    cyc(1, 0, 0, 0);
    check("vsync_mode", vcd_mode, 1'b1);
    check("vsync_src_reset", src_reset, 1'b1);
    cyc(0, 0, 0, 0);
    check("vsync_src_reset_end", src_reset, 1'b0);

    // Four-pixel line with six strobes: exactly four pops and four pixels.
    line_width = 10'd4;
    cyc(0, 1, 0, 1);
    check("hsync_src_reset", src_reset, 1'b1);
    pop_cnt = 0;
    pv_cnt = 0;
    repeat (6) cyc(0, 0, 1, 1);
    check("line4_pops", pop_cnt, 4);
    check("line4_pixels", pv_cnt, 4);

    // FIFO empty for the second and third pixels of a line.
    check("ur_before", underrun_count, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    check("ur_pix2_black", pix_data, 0);
    cyc(0, 0, 1, 0);
    check("ur_pix3_black", pix_data, 0);
    cyc(0, 0, 1, 1);
    check("ur_after", underrun_count, 2);
    // A strobe after the line ends is dropped: no pop and no count.
    cyc(0, 0, 1, 0);
    check("wait_drop_ur", underrun_count, 2);

    // Toggling the requested mode mid-line has no effect until the next vsync.
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 1);
    vcd_mode_req = 1'b0;
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    check("mode_hold", vcd_mode, 1'b1);
    cyc(1, 0, 0, 1);
    check("mode_new_frame", vcd_mode, 1'b0);

    // hsync after pixel 2 of a 352-pixel line restarts the count.
    line_width = 10'd352;
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    check("trunc_no_pixel", pix_valid, 1'b0);
    pv_cnt = 0;
    repeat (360) cyc(0, 0, 1, 1);
    check("trunc_full_line", pv_cnt, 352);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      vcd_mode_req = 1'($urandom());
      line_width = CW'($urandom_range(1, 6));
      cyc(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 8),
          ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 75));
    end

    // 300 underruns saturate the counter at 255.
    line_width = 10'd400;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (300) cyc(0, 0, 1, 0);
    check("ur_saturate", underrun_count, 255);

    // vsync with hsync: vsync wins, and no line starts.
    cyc(1, 1, 0, 1);
    cyc(0, 0, 1, 1);
    check("vs_hs_no_line", pix_valid, 1'b0);

    // A zero-width line keeps the block waiting.
    line_width = 10'd0;
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 1);
    check("zero_width", pix_valid, 1'b0);

    // Reset mid-line aborts immediately and masks the pop.
    line_width = 10'd8;
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 1);
    vsync = 1'b0;
    hsync = 1'b0;
    newpixel = 1'b1;
    fifo_valid = 1'b1;
    #1;
    check("pre_abort_ready", fifo_ready, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort_ready", fifo_ready, 1'b0);
    check("abort_pix_valid", pix_valid, 1'b0);
    check("abort_underrun", underrun_count, 0);
    model_reset();
    @(posedge clk30);
    #1;
    reset_n = 1'b1;
    cyc(0, 0, 1, 1);
    check("abort_idle", pix_valid, 1'b0);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
